// File: rtl/axi_lite_xbar_arb.sv
// Two-master to one-slave AXI-lite arbiter: the IFU (read-only) and the LSU (read/write) share one slave port.
// A single transaction is in flight at a time. The grant is held until its response handshake completes.
module axi_lite_xbar_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ifu_ar_valid_i,
    input  logic [ADDR_W-1:0] ifu_ar_addr_i,
    output logic              ifu_ar_ready_o,
    output logic              ifu_r_valid_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic [1:0]        ifu_r_resp_o,
    input  logic              ifu_r_ready_i,
    input  logic              lsu_ar_valid_i,
    input  logic [ADDR_W-1:0] lsu_ar_addr_i,
    output logic              lsu_ar_ready_o,
    output logic              lsu_r_valid_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic [1:0]        lsu_r_resp_o,
    input  logic              lsu_r_ready_i,
    input  logic              lsu_aw_valid_i,
    input  logic [ADDR_W-1:0] lsu_aw_addr_i,
    output logic              lsu_aw_ready_o,
    input  logic              lsu_w_valid_i,
    input  logic [DATA_W-1:0] lsu_w_data_i,
    input  logic [STRB_W-1:0] lsu_w_strb_i,
    output logic              lsu_w_ready_o,
    output logic              lsu_b_valid_o,
    output logic [1:0]        lsu_b_resp_o,
    input  logic              lsu_b_ready_i,
    output logic              slv_ar_valid_o,
    output logic [ADDR_W-1:0] slv_ar_addr_o,
    input  logic              slv_ar_ready_i,
    input  logic              slv_r_valid_i,
    input  logic [DATA_W-1:0] slv_r_data_i,
    input  logic [1:0]        slv_r_resp_i,
    output logic              slv_r_ready_o,
    output logic              slv_aw_valid_o,
    output logic [ADDR_W-1:0] slv_aw_addr_o,
    input  logic              slv_aw_ready_i,
    output logic              slv_w_valid_o,
    output logic [DATA_W-1:0] slv_w_data_o,
    output logic [STRB_W-1:0] slv_w_strb_o,
    input  logic              slv_w_ready_i,
    input  logic              slv_b_valid_i,
    input  logic [1:0]        slv_b_resp_i,
    output logic              slv_b_ready_o
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_GNT_IFU_R = 4'b0010,
        ST_GNT_LSU_R = 4'b0100,
        ST_GNT_LSU_W = 4'b1000
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_lsu_r;
    logic   last_lsu_nxt_s;
    logic   req_ifu_s;
    logic   req_lsu_s;

    assign req_ifu_s = ifu_ar_valid_i;
    assign req_lsu_s = lsu_ar_valid_i | lsu_aw_valid_i;

    // State and round-robin history registers; last_lsu resets high so the IFU wins the first contention.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            last_lsu_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            last_lsu_r <= last_lsu_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, release the grant on the response handshake.
    always_comb begin
        state_nxt_s    = state_r;
        last_lsu_nxt_s = last_lsu_r;
        case (state_r)
            ST_IDLE: begin
                if (req_ifu_s && (!req_lsu_s || last_lsu_r)) begin
                    state_nxt_s    = ST_GNT_IFU_R;
                    last_lsu_nxt_s = 1'b0;
                end else if (req_lsu_s) begin
                    last_lsu_nxt_s = 1'b1;
                    // The LSU read goes first when it also has a write pending.
                    if (lsu_ar_valid_i) begin
                        state_nxt_s = ST_GNT_LSU_R;
                    end else begin
                        state_nxt_s = ST_GNT_LSU_W;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT_IFU_R: begin
                if (slv_r_valid_i && ifu_r_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT_IFU_R;
                end
            end
            ST_GNT_LSU_R: begin
                if (slv_r_valid_i && lsu_r_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT_LSU_R;
                end
            end
            ST_GNT_LSU_W: begin
                if (slv_b_valid_i && lsu_b_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GNT_LSU_W;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Channel routing: the granted master's channels pass straight through; all other outputs stay 0.
    always_comb begin
        ifu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_data_o   = {DATA_W{1'b0}};
        ifu_r_resp_o   = 2'b00;
        lsu_ar_ready_o = 1'b0;
        lsu_r_valid_o  = 1'b0;
        lsu_r_data_o   = {DATA_W{1'b0}};
        lsu_r_resp_o   = 2'b00;
        lsu_aw_ready_o = 1'b0;
        lsu_w_ready_o  = 1'b0;
        lsu_b_valid_o  = 1'b0;
        lsu_b_resp_o   = 2'b00;
        slv_ar_valid_o = 1'b0;
        slv_ar_addr_o  = {ADDR_W{1'b0}};
        slv_r_ready_o  = 1'b0;
        slv_aw_valid_o = 1'b0;
        slv_aw_addr_o  = {ADDR_W{1'b0}};
        slv_w_valid_o  = 1'b0;
        slv_w_data_o   = {DATA_W{1'b0}};
        slv_w_strb_o   = {STRB_W{1'b0}};
        slv_b_ready_o  = 1'b0;
        case (state_r)
            ST_GNT_IFU_R: begin
                slv_ar_valid_o = ifu_ar_valid_i;
                slv_ar_addr_o  = ifu_ar_addr_i;
                ifu_ar_ready_o = slv_ar_ready_i;
                ifu_r_valid_o  = slv_r_valid_i;
                ifu_r_data_o   = slv_r_data_i;
                ifu_r_resp_o   = slv_r_resp_i;
                slv_r_ready_o  = ifu_r_ready_i;
            end
            ST_GNT_LSU_R: begin
                slv_ar_valid_o = lsu_ar_valid_i;
                slv_ar_addr_o  = lsu_ar_addr_i;
                lsu_ar_ready_o = slv_ar_ready_i;
                lsu_r_valid_o  = slv_r_valid_i;
                lsu_r_data_o   = slv_r_data_i;
                lsu_r_resp_o   = slv_r_resp_i;
                slv_r_ready_o  = lsu_r_ready_i;
            end
            ST_GNT_LSU_W: begin
                slv_aw_valid_o = lsu_aw_valid_i;
                slv_aw_addr_o  = lsu_aw_addr_i;
                lsu_aw_ready_o = slv_aw_ready_i;
                slv_w_valid_o  = lsu_w_valid_i;
                slv_w_data_o   = lsu_w_data_i;
                slv_w_strb_o   = lsu_w_strb_i;
                lsu_w_ready_o  = slv_w_ready_i;
                lsu_b_valid_o  = slv_b_valid_i;
                lsu_b_resp_o   = slv_b_resp_i;
                slv_b_ready_o  = lsu_b_ready_i;
            end
            default: begin
                slv_ar_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_xbar_arb.sv
// Directed bench for axi_lite_xbar_arb: a table of arbitration vectors, then hand-written
// sequences for the slow-W write with a pending IFU request and for reset in the middle of a grant.
module tb_axi_lite_xbar_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
    logic [31:0] ifu_ar_addr, ifu_r_data;
    logic [1:0]  ifu_r_resp;
    logic        lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
    logic [31:0] lsu_ar_addr, lsu_r_data;
    logic [1:0]  lsu_r_resp;
    logic        lsu_aw_valid, lsu_aw_ready, lsu_w_valid, lsu_w_ready;
    logic [31:0] lsu_aw_addr, lsu_w_data;
    logic [3:0]  lsu_w_strb;
    logic        lsu_b_valid, lsu_b_ready;
    logic [1:0]  lsu_b_resp;
    logic        slv_ar_valid, slv_ar_ready, slv_r_valid, slv_r_ready;
    logic [31:0] slv_ar_addr, slv_r_data;
    logic [1:0]  slv_r_resp;
    logic        slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready;
    logic [31:0] slv_aw_addr, slv_w_data;
    logic [3:0]  slv_w_strb;
    logic        slv_b_valid, slv_b_ready;
    logic [1:0]  slv_b_resp;

    int checks = 0;
    int errors = 0;
    int b_cnt;

    axi_lite_xbar_arb #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ifu_ar_valid_i(ifu_ar_valid), .ifu_ar_addr_i(ifu_ar_addr), .ifu_ar_ready_o(ifu_ar_ready),
        .ifu_r_valid_o(ifu_r_valid), .ifu_r_data_o(ifu_r_data), .ifu_r_resp_o(ifu_r_resp), .ifu_r_ready_i(ifu_r_ready),
        .lsu_ar_valid_i(lsu_ar_valid), .lsu_ar_addr_i(lsu_ar_addr), .lsu_ar_ready_o(lsu_ar_ready),
        .lsu_r_valid_o(lsu_r_valid), .lsu_r_data_o(lsu_r_data), .lsu_r_resp_o(lsu_r_resp), .lsu_r_ready_i(lsu_r_ready),
        .lsu_aw_valid_i(lsu_aw_valid), .lsu_aw_addr_i(lsu_aw_addr), .lsu_aw_ready_o(lsu_aw_ready),
        .lsu_w_valid_i(lsu_w_valid), .lsu_w_data_i(lsu_w_data), .lsu_w_strb_i(lsu_w_strb), .lsu_w_ready_o(lsu_w_ready),
        .lsu_b_valid_o(lsu_b_valid), .lsu_b_resp_o(lsu_b_resp), .lsu_b_ready_i(lsu_b_ready),
        .slv_ar_valid_o(slv_ar_valid), .slv_ar_addr_o(slv_ar_addr), .slv_ar_ready_i(slv_ar_ready),
        .slv_r_valid_i(slv_r_valid), .slv_r_data_i(slv_r_data), .slv_r_resp_i(slv_r_resp), .slv_r_ready_o(slv_r_ready),
        .slv_aw_valid_o(slv_aw_valid), .slv_aw_addr_o(slv_aw_addr), .slv_aw_ready_i(slv_aw_ready),
        .slv_w_valid_o(slv_w_valid), .slv_w_data_o(slv_w_data), .slv_w_strb_o(slv_w_strb), .slv_w_ready_i(slv_w_ready),
        .slv_b_valid_i(slv_b_valid), .slv_b_resp_i(slv_b_resp), .slv_b_ready_o(slv_b_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_ar;
        logic        lsu_ar;
        logic        lsu_aw;
        logic [1:0]  exp_gnt;   // 0 = IFU read, 1 = LSU read, 2 = LSU write
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] hs_vec();
        return {ifu_ar_ready, ifu_r_valid, lsu_ar_ready, lsu_r_valid, lsu_aw_ready, lsu_w_ready,
                lsu_b_valid, slv_ar_valid, slv_r_ready, slv_aw_valid, slv_w_valid, slv_b_ready};
    endfunction

    task automatic clear_inputs();
        ifu_ar_valid = 1'b0; ifu_ar_addr = 32'h0; ifu_r_ready = 1'b0;
        lsu_ar_valid = 1'b0; lsu_ar_addr = 32'h0; lsu_r_ready = 1'b0;
        lsu_aw_valid = 1'b0; lsu_aw_addr = 32'h0;
        lsu_w_valid = 1'b0; lsu_w_data = 32'h0; lsu_w_strb = 4'h0; lsu_b_ready = 1'b0;
        slv_ar_ready = 1'b0; slv_r_valid = 1'b0; slv_r_data = 32'h0; slv_r_resp = 2'b00;
        slv_aw_ready = 1'b0; slv_w_ready = 1'b0; slv_b_valid = 1'b0; slv_b_resp = 2'b00;
    endtask

    initial begin
        // Expected grants are hand-derived from the round-robin history (last_lsu starts at 1).
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h1000_0000, 32'h1111_0000, 2'b00}; // from reset: IFU
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h1000_0040, 32'h2222_0001, 2'b00}; // LSU's turn
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h1000_0080, 32'h3333_0002, 2'b01}; // IFU again
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h1000_00C0, 32'h4444_0003, 2'b00}; // LSU write wins
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h1000_0100, 32'h5555_0004, 2'b00}; // read before write
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h1000_0140, 32'h6666_0005, 2'b11}; // lone write
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h1000_0180, 32'h7777_0006, 2'b00}; // IFU after LSU
        vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h1000_01C0, 32'h8888_0007, 2'b10}; // SLVERR read
        vecs[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00}; // IFU fetch
        vecs[9] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h8000_0004, 32'h0BAD_F00D, 2'b01}; // IFU only

        clear_inputs();
        rst_i = 1'b0;
        ifu_ar_valid = 1'b1; lsu_aw_valid = 1'b1; slv_ar_ready = 1'b1; slv_r_valid = 1'b1; slv_b_valid = 1'b1;
        ifu_r_ready = 1'b1; lsu_b_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_hs", {52'h0, hs_vec()}, 64'h0);
        clear_inputs();
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            logic [31:0] exp_addr;
            ifu_ar_valid = vecs[i].ifu_ar; ifu_ar_addr = vecs[i].addr;
            lsu_ar_valid = vecs[i].lsu_ar; lsu_ar_addr = vecs[i].addr ^ 32'h0000_1000;
            lsu_aw_valid = vecs[i].lsu_aw; lsu_aw_addr = vecs[i].addr ^ 32'h0000_2000;
            slv_ar_ready = 1'b1; slv_aw_ready = 1'b1; slv_w_ready = 1'b1;
            @(posedge clk); @(negedge clk); #1;
            chk($sformatf("v%0d_gnt", i), {61'h0, ifu_ar_ready, lsu_ar_ready, lsu_aw_ready},
                {61'h0, vecs[i].exp_gnt == 2'd0, vecs[i].exp_gnt == 2'd1, vecs[i].exp_gnt == 2'd2});
            if (vecs[i].exp_gnt == 2'd2) begin
                chk($sformatf("v%0d_aw_addr", i), {32'h0, slv_aw_addr}, {32'h0, vecs[i].addr ^ 32'h0000_2000});
                chk($sformatf("v%0d_ar_blk", i), {63'h0, slv_ar_valid}, 64'h0);
                lsu_w_valid = 1'b1; lsu_w_data = vecs[i].data; lsu_w_strb = 4'hF;
                slv_b_valid = 1'b1; slv_b_resp = vecs[i].resp; lsu_b_ready = 1'b1;
                #1;
                chk($sformatf("v%0d_w_data", i), {32'h0, slv_w_data}, {32'h0, vecs[i].data});
                chk($sformatf("v%0d_b", i), {61'h0, lsu_b_valid, lsu_b_resp}, {61'h0, 1'b1, vecs[i].resp});
            end else begin
                exp_addr = (vecs[i].exp_gnt == 2'd0) ? vecs[i].addr : (vecs[i].addr ^ 32'h0000_1000);
                chk($sformatf("v%0d_ar_addr", i), {32'h0, slv_ar_addr}, {32'h0, exp_addr});
                chk($sformatf("v%0d_aw_blk", i), {63'h0, slv_aw_valid}, 64'h0);
                slv_r_valid = 1'b1; slv_r_data = vecs[i].data; slv_r_resp = vecs[i].resp;
                ifu_r_ready = 1'b1; lsu_r_ready = 1'b1;
                #1;
                if (vecs[i].exp_gnt == 2'd0) begin
                    chk($sformatf("v%0d_ifu_r", i), {29'h0, ifu_r_valid, ifu_r_data, ifu_r_resp, lsu_r_valid},
                        {29'h0, 1'b1, vecs[i].data, vecs[i].resp, 1'b0});
                end else begin
                    chk($sformatf("v%0d_lsu_r", i), {29'h0, lsu_r_valid, lsu_r_data, lsu_r_resp, ifu_r_valid},
                        {29'h0, 1'b1, vecs[i].data, vecs[i].resp, 1'b0});
                end
            end
            @(posedge clk); @(negedge clk); #1;
            chk($sformatf("v%0d_idle", i), {52'h0, hs_vec()}, 64'h0);
            clear_inputs();
        end

        // LSU write with W ready two cycles after AW while an IFU fetch waits.
        b_cnt = 0;
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h0000_0100; ifu_r_ready = 1'b1;
        lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_0010;
        lsu_w_valid = 1'b1; lsu_w_data = 32'h1234_5678; lsu_w_strb = 4'hF; lsu_b_ready = 1'b1;
        slv_ar_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        slv_aw_ready = 1'b1; #1;
        chk("w_aw_ready", {61'h0, lsu_aw_ready, lsu_w_ready, ifu_ar_ready}, {61'h0, 3'b100});
        chk("w_aw_addr", {32'h0, slv_aw_addr}, 64'h8000_0010);
        chk("w_ar_blk1", {63'h0, slv_ar_valid}, 64'h0);
        b_cnt += int'(lsu_b_valid);
        @(posedge clk); @(negedge clk);
        lsu_aw_valid = 1'b0; slv_aw_ready = 1'b0; #1;
        chk("w_ifu_blk2", {62'h0, ifu_ar_ready, slv_ar_valid}, 64'h0);
        b_cnt += int'(lsu_b_valid);
        @(posedge clk); @(negedge clk);
        slv_w_ready = 1'b1; #1;
        chk("w_strb", {60'h0, slv_w_strb}, 64'hF);
        chk("w_data", {31'h0, lsu_w_ready, slv_w_data}, {31'h0, 1'b1, 32'h1234_5678});
        chk("w_ifu_blk3", {62'h0, ifu_ar_ready, slv_ar_valid}, 64'h0);
        b_cnt += int'(lsu_b_valid);
        @(posedge clk); @(negedge clk);
        lsu_w_valid = 1'b0; slv_w_ready = 1'b0; slv_b_valid = 1'b1; slv_b_resp = 2'b00; #1;
        chk("w_b_valid", {63'h0, lsu_b_valid}, 64'h1);
        chk("w_ifu_blk4", {62'h0, ifu_ar_ready, slv_ar_valid}, 64'h0);
        b_cnt += int'(lsu_b_valid);
        @(posedge clk); @(negedge clk);
        slv_b_valid = 1'b0; #1;
        b_cnt += int'(lsu_b_valid);
        chk("w_idle_blk", {62'h0, ifu_ar_ready, slv_ar_valid}, 64'h0);
        chk("w_b_pulses", b_cnt, 64'd1);
        @(posedge clk); @(negedge clk); #1;
        chk("w_ifu_gnt", {31'h0, ifu_ar_ready, slv_ar_addr}, {31'h0, 1'b1, 32'h0000_0100});
        slv_r_valid = 1'b1; slv_r_data = 32'hCAFE_0001; #1;
        chk("w_ifu_rdata", {32'h0, ifu_r_data}, 64'hCAFE_0001);
        @(posedge clk); @(negedge clk); #1;
        chk("w_ifu_done", {52'h0, hs_vec()}, 64'h0);
        clear_inputs();

        // Reset asserted between clock edges while the IFU holds the grant.
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h0000_0200; slv_ar_ready = 1'b1;
        slv_r_valid = 1'b1; slv_r_data = 32'h0000_00AA;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_pre_gnt", {62'h0, ifu_ar_ready, ifu_r_valid}, 64'h3);
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async_hs", {52'h0, hs_vec()}, 64'h0);
        lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h0000_0300;
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_first_gnt", {62'h0, ifu_ar_ready, lsu_ar_ready}, 64'h2);
        ifu_r_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_done_idle", {52'h0, hs_vec()}, 64'h0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
